// File: rtl/cache_data_mem_banked.sv
// Banked, pixel-masked cache line store with a held valid/ready read stage.
// Optional same-line write forwarding is enabled by defining CACHE_DMEM_FWD_EN.
module cache_data_mem_banked #(
  parameter int unsigned PIXEL_BITS  = 8,
  parameter int unsigned LINE_PIXELS = 48,
  parameter int unsigned LG_BANKS    = 2,
  parameter int unsigned IDX_WDTH    = 5,
  parameter int unsigned ADDR_WDTH   = IDX_WDTH + LG_BANKS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              rd_valid_in,
  output logic                              rd_ready_out,
  input  logic [ADDR_WDTH-1:0]              rd_addr_in,
  output logic                              rd_valid_out,
  input  logic                              rd_ready_in,
  output logic [PIXEL_BITS*LINE_PIXELS-1:0] rd_data_out,
  input  logic                              wr_valid_in,
  output logic                              wr_ready_out,
  input  logic [ADDR_WDTH-1:0]              wr_addr_in,
  input  logic [PIXEL_BITS*LINE_PIXELS-1:0] wr_data_in,
  input  logic [LINE_PIXELS-1:0]            wr_mask_in,
  output logic [15:0]                       stall_cnt_out
);

  localparam int unsigned N_BANKS = 1 << LG_BANKS;
  localparam int unsigned DEPTH   = 1 << IDX_WDTH;

  typedef logic [LINE_PIXELS-1:0][PIXEL_BITS-1:0] line_t;

  logic [LG_BANKS-1:0] rd_bank, wr_bank;
  logic [IDX_WDTH-1:0] rd_idx, wr_idx;
  logic                wr_fire, rd_fire;
  logic                conflict, conflict_block, out_free;
  line_t               bank_rd [N_BANKS];
  line_t               sel_line, next_line;
  logic                rd_valid_q;
  line_t               rd_data_q;
  logic [15:0]         stall_cnt;

  assign rd_bank = rd_addr_in[LG_BANKS-1:0];
  assign rd_idx  = rd_addr_in[ADDR_WDTH-1:LG_BANKS];
  assign wr_bank = wr_addr_in[LG_BANKS-1:0];
  assign wr_idx  = wr_addr_in[ADDR_WDTH-1:LG_BANKS];

  assign wr_fire  = wr_valid_in && !reset;
  assign conflict = wr_valid_in && rd_valid_in && (rd_bank == wr_bank);
  assign out_free = !rd_valid_q || rd_ready_in;

`ifdef CACHE_DMEM_FWD_EN
  logic fwd_hit;
  // Same line: the bank reads old contents first, the masked write data is merged on the way into the output register.
  assign fwd_hit        = conflict && (rd_idx == wr_idx);
  assign conflict_block = conflict && !fwd_hit;
`else
  assign conflict_block = conflict;
`endif

  assign rd_ready_out = !reset && out_free && !conflict_block;
  assign rd_fire      = rd_valid_in && rd_ready_out;
  assign wr_ready_out = !reset;

  // One storage array per bank and pixel lane, so each mask bit is a lane write enable.
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    localparam logic [LG_BANKS-1:0] BANK_ID = LG_BANKS'(b);
    logic bank_we;
    assign bank_we = wr_fire && (wr_bank == BANK_ID);

    for (genvar p = 0; p < LINE_PIXELS; p++) begin : g_lane
      logic [PIXEL_BITS-1:0] lane [DEPTH];

      always_ff @(posedge clk) begin
        if (bank_we && wr_mask_in[p]) begin
          lane[wr_idx] <= wr_data_in[p*PIXEL_BITS +: PIXEL_BITS];
        end
      end

      assign bank_rd[b][p] = lane[rd_idx];
    end
  end

  assign sel_line = bank_rd[rd_bank];

`ifdef CACHE_DMEM_FWD_EN
  for (genvar p = 0; p < LINE_PIXELS; p++) begin : g_merge
    assign next_line[p] = (fwd_hit && wr_mask_in[p]) ?
                          wr_data_in[p*PIXEL_BITS +: PIXEL_BITS] : sel_line[p];
  end
`else
  assign next_line = sel_line;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_fire) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= next_line;
    end else if (rd_ready_in) begin
      rd_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (rd_valid_in && conflict_block && out_free && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign rd_valid_out  = rd_valid_q;
  assign rd_data_out   = rd_data_q;
  assign stall_cnt_out = stall_cnt;

endmodule
